// File: rtl/i2c_frame_tx.sv
// I2C write engine: START, address byte (write), two data bytes, STOP.
// SCL/SDA_OE are decoded from the FSM state so a reset releases the bus at once.
module i2c_frame_tx #(
   parameter int          CLK_DIV  = 4,
   parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
   input  logic        CLK,
   input  logic        NRESET,
   input  logic        i_START,
   input  logic [15:0] i_DATA,
   output logic        o_BUSY,
   output logic        o_DONE,
   output logic        o_ACK_ERR,
   output logic        SCL,
   output logic        SDA_OE,
   input  logic        SDA_IN
);

   localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [23:0]   shift_q, shift_d;
   logic          err_q, err_d;
   logic          nack_q, nack_d;
   logic          wrap;

   always_ff @(posedge CLK or negedge NRESET) begin
      if (!NRESET) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         err_q   <= 1'b0;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         err_q   <= err_d;
         nack_q  <= nack_d;
      end
   end

   assign wrap = (tmr_q == TMAX);

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      err_d   = err_q;
      nack_d  = nack_q;
      SCL     = 1'b1;
      SDA_OE  = 1'b0;

      // Quarter timing runs in every timed state; IDLE and DONE force it to zero.
      if (state_q != S_IDLE && state_q != S_DONE) begin
         tmr_d = wrap ? '0 : tmr_q + TW'(1);
         qtr_d = wrap ? qtr_q + 2'd1 : qtr_q;
      end

      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            qtr_d = '0;
            if (i_START) begin
               shift_d = {DEV_ADDR, 1'b0, i_DATA};
               err_d   = 1'b0;
               nack_d  = 1'b0;
               bit_d   = '0;
               byte_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            SDA_OE = (qtr_q == 2'd1);
            if (wrap && qtr_q == 2'd1) begin
               qtr_d   = '0;
               state_d = S_BIT;
            end
         end
         S_BIT: begin
            SCL    = qtr_q[1];
            SDA_OE = ~shift_q[23];
            if (wrap && qtr_q == 2'd3) begin
               shift_d = {shift_q[22:0], 1'b0};
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = S_ACK;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_ACK: begin
            SCL = qtr_q[1];
            // Sample late in the SCL-high half so the slave has settled.
            if (wrap && qtr_q == 2'd2) begin
               nack_d = SDA_IN;
               if (SDA_IN) err_d = 1'b1;
            end
            if (wrap && qtr_q == 2'd3) begin
               if (nack_q || byte_q == 2'd2) begin
                  state_d = S_STOP;
               end else begin
                  byte_d  = byte_q + 2'd1;
                  state_d = S_BIT;
               end
            end
         end
         S_STOP: begin
            SCL    = (qtr_q != 2'd0);
            SDA_OE = (qtr_q != 2'd2);
            if (wrap && qtr_q == 2'd2) begin
               tmr_d   = '0;
               qtr_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            tmr_d   = '0;
            qtr_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_BUSY    = (state_q != S_IDLE);
   assign o_DONE    = (state_q == S_DONE);
   assign o_ACK_ERR = err_q;

endmodule

// File: tb/tb_i2c_frame_tx.sv
// Directed bench for i2c_frame_tx: bus decoder, open-drain slave model, scenario tasks.
module tb_i2c_frame_tx;

   logic        CLK = 1'b0;
   logic        NRESET = 1'b0;
   logic        i_START = 1'b0;
   logic [15:0] i_DATA = 16'h0000;
   logic        o_BUSY, o_DONE, o_ACK_ERR, SCL, SDA_OE;
   logic        SDA_IN;

   int checks = 0;
   int failures = 0;

   // slave model: byte index that gets NACKed (-1 = ACK everything)
   int   nack_byte = -1;
   logic ack_pull = 1'b0;
   assign SDA_IN = SDA_OE ? 1'b0 : ~ack_pull;

   i2c_frame_tx #(.CLK_DIV(4), .DEV_ADDR(7'h1A)) dut (
      .CLK(CLK), .NRESET(NRESET), .i_START(i_START), .i_DATA(i_DATA),
      .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ACK_ERR(o_ACK_ERR),
      .SCL(SCL), .SDA_OE(SDA_OE), .SDA_IN(SDA_IN)
   );

   always #5 CLK = ~CLK;

   // bus decoder: START/STOP edges, bits on SCL rise, 9th rise is the ACK slot
   logic       prev_scl = 1'b1;
   logic       prev_oe = 1'b0;
   int         bitcnt = 0;
   int         byte_idx = 0;
   int         start_cnt = 0;
   int         stop_cnt = 0;
   logic [7:0] sh = 8'h00;
   logic [7:0] bytes_q[$];

   always @(negedge CLK) begin
      if (prev_scl && SCL && !prev_oe && SDA_OE) begin
         start_cnt++;
         bitcnt = 0;
         byte_idx = 0;
      end else if (prev_scl && SCL && prev_oe && !SDA_OE) begin
         stop_cnt++;
      end else if (!prev_scl && SCL) begin
         if (bitcnt < 8) begin
            sh = {sh[6:0], ~SDA_OE};
            bitcnt++;
         end else begin
            bytes_q.push_back(sh);
            byte_idx++;
            bitcnt = 0;
         end
      end else if (prev_scl && !SCL) begin
         ack_pull = (bitcnt == 8) && (byte_idx != nack_byte);
      end
      prev_scl = SCL;
      prev_oe  = SDA_OE;
   end

   // Issues one frame and watches it until 20 cycles past the first o_DONE.
   task automatic run_frame(input logic [15:0] data, input int inject_at,
                            output int done_cyc, output int done_cnt,
                            output logic busy1, output logic err1, output logic err_done);
      int cnt;
      @(negedge CLK);
      i_DATA = data;
      i_START = 1'b1;
      cnt = 0;
      done_cyc = -1;
      done_cnt = 0;
      busy1 = 1'b0;
      err1 = 1'b1;
      err_done = 1'bx;
      while (cnt < 600 && !(done_cnt > 0 && cnt > done_cyc + 20)) begin
         @(negedge CLK);
         cnt++;
         if (cnt == 1) begin
            busy1 = o_BUSY;
            err1 = o_ACK_ERR;
            i_START = 1'b0;
            i_DATA = ~data;
         end
         if (cnt == inject_at) begin
            i_START = 1'b1;
            i_DATA = 16'hFFFF;
         end else if (cnt == inject_at + 1) begin
            i_START = 1'b0;
         end
         if (o_DONE) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = cnt;
               err_done = o_ACK_ERR;
            end
         end
      end
      i_START = 1'b0;
   endtask

   task automatic test_reset();
      int bad_cycles;
      NRESET = 1'b0;
      repeat (2) @(negedge CLK);
      NRESET = 1'b1;
      bad_cycles = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         checks++;
         if ({SCL, SDA_OE, o_BUSY, o_DONE, o_ACK_ERR} !== 5'b10000) begin
            failures++;
            bad_cycles++;
            if (bad_cycles < 4)
               $display("FAIL reset_idle cyc=%0d got scl/oe/busy/done/err=%b want 10000", i, {SCL, SDA_OE, o_BUSY, o_DONE, o_ACK_ERR});
         end
      end
      $display("test_reset: 50 idle cycles checked, bad=%0d", bad_cycles);
   endtask

   task automatic test_nominal();
      int dc, dn, s0, p0;
      logic b1, e1, ed;
      bytes_q.delete();
      nack_byte = -1;
      s0 = start_cnt; p0 = stop_cnt;
      run_frame(16'h1E00, -1, dc, dn, b1, e1, ed);
      checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL nom_busy got %b want 1", b1); end
      checks++; if (dc !== 453) begin failures++; $display("FAIL nom_latency got %0d want 453", dc); end
      checks++; if (dn !== 1) begin failures++; $display("FAIL nom_done_cnt got %0d want 1", dn); end
      checks++; if (ed !== 1'b0) begin failures++; $display("FAIL nom_ack_err got %b want 0", ed); end
      checks++; if (bytes_q.size() !== 3) begin failures++; $display("FAIL nom_nbytes got %0d want 3", bytes_q.size()); end
      else begin
         checks++; if (bytes_q[0] !== 8'h34) begin failures++; $display("FAIL nom_b0 got %h want 34", bytes_q[0]); end
         checks++; if (bytes_q[1] !== 8'h1E) begin failures++; $display("FAIL nom_b1 got %h want 1e", bytes_q[1]); end
         checks++; if (bytes_q[2] !== 8'h00) begin failures++; $display("FAIL nom_b2 got %h want 00", bytes_q[2]); end
      end
      checks++; if (start_cnt - s0 !== 1 || stop_cnt - p0 !== 1) begin failures++; $display("FAIL nom_start_stop got %0d/%0d want 1/1", start_cnt - s0, stop_cnt - p0); end
      checks++; if (o_BUSY !== 1'b0 || SCL !== 1'b1 || SDA_OE !== 1'b0) begin failures++; $display("FAIL nom_idle_after got busy=%b scl=%b oe=%b want 0 1 0", o_BUSY, SCL, SDA_OE); end
      $display("test_nominal: done at %0d, %0d bytes", dc, bytes_q.size());
   endtask

   task automatic test_addr_nack();
      int dc, dn, p0;
      logic b1, e1, ed;
      bytes_q.delete();
      nack_byte = 0;
      p0 = stop_cnt;
      run_frame(16'h1E00, -1, dc, dn, b1, e1, ed);
      nack_byte = -1;
      checks++; if (dc !== 165) begin failures++; $display("FAIL nack_latency got %0d want 165", dc); end
      checks++; if (ed !== 1'b1) begin failures++; $display("FAIL nack_err got %b want 1", ed); end
      checks++; if (bytes_q.size() !== 1) begin failures++; $display("FAIL nack_nbytes got %0d want 1", bytes_q.size()); end
      else begin
         checks++; if (bytes_q[0] !== 8'h34) begin failures++; $display("FAIL nack_b0 got %h want 34", bytes_q[0]); end
      end
      checks++; if (stop_cnt - p0 !== 1) begin failures++; $display("FAIL nack_stop got %0d want 1", stop_cnt - p0); end
      checks++; if (o_ACK_ERR !== 1'b1) begin failures++; $display("FAIL nack_sticky got %b want 1", o_ACK_ERR); end
      $display("test_addr_nack: done at %0d, %0d bytes", dc, bytes_q.size());
   endtask

   task automatic test_sticky_clear();
      int dc, dn;
      logic b1, e1, ed;
      checks++; if (o_ACK_ERR !== 1'b1) begin failures++; $display("FAIL sticky_pre got %b want 1", o_ACK_ERR); end
      bytes_q.delete();
      run_frame(16'h5A3C, -1, dc, dn, b1, e1, ed);
      checks++; if (e1 !== 1'b0) begin failures++; $display("FAIL sticky_clear got %b want 0", e1); end
      checks++; if (ed !== 1'b0) begin failures++; $display("FAIL sticky_done got %b want 0", ed); end
      checks++; if (dc !== 453) begin failures++; $display("FAIL sticky_latency got %0d want 453", dc); end
      checks++; if (bytes_q.size() !== 3) begin failures++; $display("FAIL sticky_nbytes got %0d want 3", bytes_q.size()); end
      else begin
         checks++; if (bytes_q[1] !== 8'h5A || bytes_q[2] !== 8'h3C) begin failures++; $display("FAIL sticky_data got %h %h want 5a 3c", bytes_q[1], bytes_q[2]); end
      end
      $display("test_sticky_clear: done at %0d", dc);
   endtask

   task automatic test_busy_ignore();
      int dc, dn;
      logic b1, e1, ed;
      bytes_q.delete();
      run_frame(16'h0C00, 100, dc, dn, b1, e1, ed);
      checks++; if (dn !== 1) begin failures++; $display("FAIL busy_done_cnt got %0d want 1", dn); end
      checks++; if (dc !== 453) begin failures++; $display("FAIL busy_latency got %0d want 453", dc); end
      checks++; if (bytes_q.size() !== 3) begin failures++; $display("FAIL busy_nbytes got %0d want 3", bytes_q.size()); end
      else begin
         checks++; if (bytes_q[1] !== 8'h0C || bytes_q[2] !== 8'h00) begin failures++; $display("FAIL busy_data got %h %h want 0c 00", bytes_q[1], bytes_q[2]); end
      end
      $display("test_busy_ignore: %0d done pulses", dn);
   endtask

   task automatic test_mid_reset();
      int dc, dn;
      logic b1, e1, ed;
      @(negedge CLK);
      i_DATA = 16'h00A5;
      i_START = 1'b1;
      for (int c = 1; c <= 201; c++) begin
         @(negedge CLK);
         if (c == 1) i_START = 1'b0;
      end
      // cycle 201 is q0 of bit 3 in byte 1 (value 0x00): SCL low, SDA pulled
      checks++; if (SCL !== 1'b0 || SDA_OE !== 1'b1 || o_BUSY !== 1'b1) begin failures++; $display("FAIL midrst_pre got scl=%b oe=%b busy=%b want 0 1 1", SCL, SDA_OE, o_BUSY); end
      #2 NRESET = 1'b0;
      #1;
      checks++; if (SCL !== 1'b1 || SDA_OE !== 1'b0 || o_BUSY !== 1'b0) begin failures++; $display("FAIL midrst_now got scl=%b oe=%b busy=%b want 1 0 0", SCL, SDA_OE, o_BUSY); end
      repeat (2) @(negedge CLK);
      NRESET = 1'b1;
      repeat (2) @(negedge CLK);
      bytes_q.delete();
      run_frame(16'h1E00, -1, dc, dn, b1, e1, ed);
      checks++; if (dc !== 453 || dn !== 1) begin failures++; $display("FAIL midrst_frame got done=%0d cnt=%0d want 453 1", dc, dn); end
      checks++; if (bytes_q.size() !== 3) begin failures++; $display("FAIL midrst_nbytes got %0d want 3", bytes_q.size()); end
      else begin
         checks++; if (bytes_q[0] !== 8'h34 || bytes_q[1] !== 8'h1E || bytes_q[2] !== 8'h00) begin failures++; $display("FAIL midrst_data got %h %h %h want 34 1e 00", bytes_q[0], bytes_q[1], bytes_q[2]); end
      end
      $display("test_mid_reset: recovery frame done at %0d", dc);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_addr_nack();
      test_sticky_clear();
      test_busy_ignore();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
